// File: rtl/hud_overlay.sv
// rtl/hud_overlay.sv - per-player damage bar, ghost drain, hit flash and stock HUD compositor
//
// Draws NUM_PLAYERS damage bars and stock-square rows over the game pixel stream.
// Damage and stock counts are latched once per frame so the HUD never tears.
// Each bar shows a coloured fill at the latched target length and a yellow ghost
// segment out to the displayed length. The displayed length drains toward the
// target by DRAIN_STEP per frame. A hit makes the outline flash for FLASH_FRAMES frames.
//
// Ports:
//   clk        pixel clock
//   reset_n    asynchronous active-low reset
//   frame_tick one-clk pulse per frame
//   col, row   current pixel position (10 bits each)
//   game_rgb   underlying pixel colour, aligned with col/row
//   damage     packed damage, player i at [10i+9:10i]
//   stocks     packed stock counts, SW bits per player
//   got_hit    one-clk hit pulse per player
//   fill_color packed 6-bit fill colour per player
//   rgb        composited pixel, registered (1 clk after col/row/game_rgb)
//   hud_active registered; 1 when the HUD drew the pixel
//   disp_fill  packed displayed fill lengths
module hud_overlay #(
    parameter int NUM_PLAYERS  = 2,
    parameter int BAR_X0       = 20,
    parameter int BAR_PITCH    = 500,
    parameter int BAR_Y        = 10,
    parameter int BAR_WIDTH    = 100,
    parameter int BAR_HEIGHT   = 15,
    parameter int MAX_STOCKS   = 3,
    parameter int DRAIN_STEP   = 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        frame_tick,
    input  logic [9:0]                                  col,
    input  logic [9:0]                                  row,
    input  logic [5:0]                                  game_rgb,
    input  logic [10*NUM_PLAYERS-1:0]                   damage,
    input  logic [$clog2(MAX_STOCKS+1)*NUM_PLAYERS-1:0] stocks,
    input  logic [NUM_PLAYERS-1:0]                      got_hit,
    input  logic [6*NUM_PLAYERS-1:0]                    fill_color,
    output logic [5:0]                                  rgb,
    output logic                                        hud_active,
    output logic [10*NUM_PLAYERS-1:0]                   disp_fill
);
    localparam int SW = $clog2(MAX_STOCKS + 1);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    localparam logic [9:0] WIDTH10 = 10'(BAR_WIDTH);
    localparam logic [9:0] STEP10  = 10'(DRAIN_STEP);

    localparam logic [5:0] GHOST_RGB = 6'b111100;
    localparam logic [5:0] EMPTY_RGB = 6'b000000;
    localparam logic [5:0] RED_RGB   = 6'b110000;
    localparam logic [5:0] WHITE_RGB = 6'b111111;

    localparam int LAST_X = BAR_X0 + (NUM_PLAYERS - 1) * BAR_PITCH;

    // Every region must lie inside the 640x480 raster.
    generate
        if (NUM_PLAYERS < 1 || MAX_STOCKS < 1 || FLASH_FRAMES < 1 ||
            BAR_X0 < 0 || BAR_Y < 0 || BAR_PITCH < 0 ||
            LAST_X + BAR_WIDTH + 4 > 640 ||
            LAST_X + 15 * (MAX_STOCKS - 1) + 10 > 640 ||
            BAR_Y + BAR_HEIGHT + 18 > 480) begin : g_bad_geometry
            $error("hud_overlay: HUD geometry does not fit inside 640x480");
        end
    endgenerate

    logic [NUM_PLAYERS-1:0] p_hit;
    logic [5:0]             p_color [NUM_PLAYERS];

    genvar i, k;
    generate
        for (i = 0; i < NUM_PLAYERS; i++) begin : g_player
            localparam int XI = BAR_X0 + i * BAR_PITCH;

            localparam logic [9:0] OL_X0 = 10'(XI);
            localparam logic [9:0] OL_X1 = 10'(XI + BAR_WIDTH + 4);
            localparam logic [9:0] OL_Y0 = 10'(BAR_Y);
            localparam logic [9:0] OL_Y1 = 10'(BAR_Y + BAR_HEIGHT + 4);
            localparam logic [9:0] IN_X0 = 10'(XI + 2);
            localparam logic [9:0] IN_X1 = 10'(XI + 2 + BAR_WIDTH);
            localparam logic [9:0] IN_Y0 = 10'(BAR_Y + 2);
            localparam logic [9:0] IN_Y1 = 10'(BAR_Y + BAR_HEIGHT + 2);
            localparam logic [9:0] SQ_Y0 = 10'(BAR_Y + BAR_HEIGHT + 8);
            localparam logic [9:0] SQ_Y1 = 10'(BAR_Y + BAR_HEIGHT + 18);

            logic [9:0]            target_q;
            logic [9:0]            disp_q;
            logic [SW-1:0]         stock_q;
            logic [FW-1:0]         flash_q;
            logic [9:0]            dmg;
            logic [9:0]            gap;
            logic [9:0]            offset;
            logic                  in_outline;
            logic                  in_interior;
            logic [MAX_STOCKS-1:0] in_stock;
            logic [5:0]            fc;

            assign dmg = damage[10*i +: 10];
            assign fc  = fill_color[6*i +: 6];
            assign gap = disp_q - target_q;

            // The drain compares against target_q before this tick's update, so a
            // new damage value starts moving the bar one frame after it is latched.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    target_q <= WIDTH10;
                    disp_q   <= WIDTH10;
                    stock_q  <= SW'(MAX_STOCKS);
                end else if (frame_tick) begin
                    target_q <= (dmg >= WIDTH10) ? 10'd0 : WIDTH10 - dmg;
                    stock_q  <= stocks[SW*i +: SW];
                    if (disp_q > target_q) begin
                        disp_q <= disp_q - ((gap > STEP10) ? STEP10 : gap);
                    end else if (disp_q < target_q) begin
                        disp_q <= target_q;
                    end
                end
            end

            // A hit reloads the counter even when a tick would decrement it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    flash_q <= '0;
                end else if (got_hit[i]) begin
                    flash_q <= FW'(FLASH_FRAMES);
                end else if (frame_tick && flash_q != '0) begin
                    flash_q <= flash_q - FW'(1);
                end
            end

            assign in_outline  = (col >= OL_X0) && (col < OL_X1) &&
                                 (row >= OL_Y0) && (row < OL_Y1);
            assign in_interior = (col >= IN_X0) && (col < IN_X1) &&
                                 (row >= IN_Y0) && (row < IN_Y1);
            assign offset      = col - IN_X0;

            for (k = 0; k < MAX_STOCKS; k++) begin : g_stock
                localparam logic [9:0] SQ_X0 = 10'(XI + 15 * k);
                localparam logic [9:0] SQ_X1 = 10'(XI + 15 * k + 10);
                assign in_stock[k] = (col >= SQ_X0) && (col < SQ_X1) &&
                                     (row >= SQ_Y0) && (row < SQ_Y1) &&
                                     (stock_q > SW'(k));
            end

            always_comb begin
                p_hit[i]   = 1'b1;
                p_color[i] = fc;
                if (in_interior) begin
                    if (offset < target_q) begin
                        p_color[i] = fc;
                    end else if (offset < disp_q) begin
                        p_color[i] = GHOST_RGB;
                    end else begin
                        p_color[i] = EMPTY_RGB;
                    end
                end else if (in_outline) begin
                    // An odd count is necessarily non-zero, so bit 0 alone selects red.
                    p_color[i] = flash_q[0] ? RED_RGB : WHITE_RGB;
                end else if (|in_stock) begin
                    p_color[i] = fc;
                end else begin
                    p_hit[i] = 1'b0;
                end
            end

            assign disp_fill[10*i +: 10] = disp_q;
        end
    endgenerate

    logic [5:0] next_rgb;
    logic       next_active;

    // Walk from the highest index down so the lowest-index player wins overlaps.
    always_comb begin
        next_rgb    = game_rgb;
        next_active = 1'b0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (p_hit[p]) begin
                next_rgb    = p_color[p];
                next_active = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb        <= 6'd0;
            hud_active <= 1'b0;
        end else begin
            rgb        <= next_rgb;
            hud_active <= next_active;
        end
    end

endmodule

// File: tb/tb_hud_overlay.sv
// tb/tb_hud_overlay.sv - self-checking bench for hud_overlay
module tb_hud_overlay;
    localparam int NP    = 2;
    localparam int X0    = 20;
    localparam int PITCH = 500;
    localparam int Y     = 10;
    localparam int W     = 100;
    localparam int H     = 15;
    localparam int MAXS  = 3;
    localparam int STEP  = 3;
    localparam int FF    = 8;
    localparam int SW    = 2;

    localparam int FC0 = 6'b001100;
    localparam int FC1 = 6'b000011;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              frame_tick = 1'b0;
    logic [9:0]        col        = '0;
    logic [9:0]        row        = '0;
    logic [5:0]        game_rgb   = '0;
    logic [10*NP-1:0]  damage     = '0;
    logic [SW*NP-1:0]  stocks     = {2'd3, 2'd3};
    logic [NP-1:0]     got_hit    = '0;
    logic [6*NP-1:0]   fill_color = {6'(FC1), 6'(FC0)};
    logic [5:0]        rgb;
    logic              hud_active;
    logic [10*NP-1:0]  disp_fill;

    hud_overlay #(
        .NUM_PLAYERS(NP), .BAR_X0(X0), .BAR_PITCH(PITCH), .BAR_Y(Y),
        .BAR_WIDTH(W), .BAR_HEIGHT(H), .MAX_STOCKS(MAXS),
        .DRAIN_STEP(STEP), .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .col(col), .row(row), .game_rgb(game_rgb),
        .damage(damage), .stocks(stocks), .got_hit(got_hit),
        .fill_color(fill_color),
        .rgb(rgb), .hud_active(hud_active), .disp_fill(disp_fill)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: per-player bar state as plain integers.
    int m_tgt  [NP];
    int m_disp [NP];
    int m_stk  [NP];
    int m_fl   [NP];

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin
            m_tgt[i] = W; m_disp[i] = W; m_stk[i] = MAXS; m_fl[i] = 0;
        end
    endfunction

    function automatic void model_pixel(input int c, input int r, input int g,
                                        output int px, output int ha);
        int x, dx, off, v, fc;
        px = g; ha = 0;
        for (int i = NP - 1; i >= 0; i--) begin
            x  = X0 + i * PITCH;
            fc = (i == 0) ? FC0 : FC1;
            v  = -1;
            dx = c - x;
            if (c >= x + 2 && c < x + 2 + W && r >= Y + 2 && r < Y + H + 2) begin
                off = c - (x + 2);
                if (off < m_tgt[i])       v = fc;
                else if (off < m_disp[i]) v = 6'b111100;
                else                      v = 0;
            end else if (c >= x && c < x + W + 4 && r >= Y && r < Y + H + 4) begin
                v = (m_fl[i] % 2 == 1) ? 6'b110000 : 6'b111111;
            end else if (dx >= 0 && dx / 15 < MAXS && dx % 15 < 10 &&
                         dx / 15 < m_stk[i] && r >= Y + H + 8 && r < Y + H + 18) begin
                v = fc;
            end
            if (v >= 0) begin px = v; ha = 1; end
        end
    endfunction

    function automatic void model_step();
        int d, old_t;
        for (int i = 0; i < NP; i++) begin
            d     = int'(damage[10*i +: 10]);
            old_t = m_tgt[i];
            if (got_hit[i])                    m_fl[i] = FF;
            else if (frame_tick && m_fl[i] > 0) m_fl[i] = m_fl[i] - 1;
            if (frame_tick) begin
                m_tgt[i] = (d >= W) ? 0 : W - d;
                m_stk[i] = int'(stocks[SW*i +: SW]);
                if (m_disp[i] > old_t)
                    m_disp[i] = m_disp[i] - ((m_disp[i] - old_t < STEP) ? m_disp[i] - old_t : STEP);
                else
                    m_disp[i] = old_t;
            end
        end
    endfunction

    int exp_rgb, exp_ha;
    bit exp_valid = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                model_reset();
                exp_valid = 0;
            end else begin
                model_pixel(int'(col), int'(row), int'(game_rgb), exp_rgb, exp_ha);
                model_step();
                exp_valid = 1;
            end
            @(negedge clk);
            if (exp_valid && reset_n) begin
                chk("rgb", int'(rgb), exp_rgb);
                chk("hud_active", int'(hud_active), exp_ha);
                for (int i = 0; i < NP; i++)
                    chk("disp_fill", int'(disp_fill[10*i +: 10]), m_disp[i]);
            end
        end
    end

    task automatic drive(input int c, input int r, input bit tick, input logic [NP-1:0] hit);
        @(negedge clk);
        col        = 10'(c);
        row        = 10'(r);
        game_rgb   = 6'($urandom);
        frame_tick = tick;
        got_hit    = hit;
    endtask

    // exp < 0 means the game pixel must pass through.
    task automatic probe(input string name, input int c, input int r, input int exp);
        int g;
        drive(c, r, 1'b0, '0);
        g = int'(game_rgb);
        @(negedge clk);
        chk(name, int'(rgb), (exp < 0) ? g : exp);
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(300, 200, 1'b1, '0);
        drive(300, 200, 1'b0, '0);
    endtask

    task automatic scan(input bit with_ticks);
        int rws [13];
        rws = '{9, 10, 11, 12, 16, 26, 27, 28, 29, 32, 33, 42, 43};
        foreach (rws[k])
            for (int p = 0; p < NP; p++)
                for (int c = X0 + p * PITCH - 3; c < X0 + p * PITCH + W + 7; c++)
                    drive(c, rws[k], with_ticks && (c % 37 == 0), '0);
        drive(300, 200, 1'b0, '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_hud", int'(hud_active), 0);
        for (int i = 0; i < NP; i++) chk("rst_disp", int'(disp_fill[10*i +: 10]), W);
        reset_n = 1'b1;

        probe("p0_fill", 50, 15, FC0);
        probe("outline_corner", 20, 10, 6'b111111);
        probe("stock0", 25, 35, FC0);
        probe("background", 300, 200, -1);
        chk("background_hud", int'(hud_active), 0);
        scan(1'b0);

        // Drain with ghost.
        damage[9:0] = 10'd12;
        ticks(1);
        chk("disp_after_latch", int'(disp_fill[9:0]), 100);
        ticks(1);
        chk("disp_first_step", int'(disp_fill[9:0]), 97);
        probe("ghost_112", 112, 15, 6'b111100);
        scan(1'b0);
        ticks(3);
        chk("disp_at_target", int'(disp_fill[9:0]), 88);
        probe("ghost_gone", 112, 15, 6'b000000);
        probe("fill_edge", 109, 15, FC0);
        damage[9:0] = 10'd40;
        probe("no_tick_ignored", 109, 15, FC0);

        // Overkill damage: clamps at zero, never wraps.
        damage[9:0] = 10'd150;
        ticks(1);
        ticks(1);
        chk("drain_85", int'(disp_fill[9:0]), 85);
        scan(1'b1);
        ticks(30);
        chk("drain_zero", int'(disp_fill[9:0]), 0);
        ticks(2);
        chk("hold_zero", int'(disp_fill[9:0]), 0);
        probe("empty_bar", 22, 15, 6'b000000);

        // Heal snaps up.
        damage[9:0] = 10'd50;
        ticks(2);
        chk("snap_50", int'(disp_fill[9:0]), 50);
        damage[9:0] = 10'd0;
        ticks(1);
        chk("heal_latch_hold", int'(disp_fill[9:0]), 50);
        ticks(1);
        chk("heal_snap_100", int'(disp_fill[9:0]), 100);

        // Stock loss.
        stocks[1:0] = 2'd1;
        probe("stock1_before_tick", 40, 35, FC0);
        ticks(1);
        probe("stock1_gone", 40, 35, -1);
        probe("stock2_gone", 55, 35, -1);
        probe("stock0_kept", 25, 35, FC0);
        scan(1'b0);

        // Hit on player 1 coinciding with a frame tick.
        drive(300, 200, 1'b1, 2'b10);
        drive(300, 200, 1'b0, '0);
        probe("flash_start", 520, 10, 6'b111111);
        for (int f = 1; f <= 4; f++) begin
            ticks(1);
            probe("flash_seq", 520, 10, ((FF - f) % 2 == 1) ? 6'b110000 : 6'b111111);
        end
        drive(300, 200, 1'b1, 2'b10);
        drive(300, 200, 1'b0, '0);
        probe("flash_restart", 520, 10, 6'b111111);
        ticks(1);
        probe("flash_7_red", 520, 10, 6'b110000);
        scan(1'b0);
        for (int f = 2; f <= FF; f++) begin
            ticks(1);
            probe("flash_seq2", 520, 10, ((FF - f) % 2 == 1) ? 6'b110000 : 6'b111111);
        end
        ticks(3);
        probe("flash_done", 520, 10, 6'b111111);

        // Asynchronous reset with a partially drained bar.
        damage[9:0] = 10'd30;
        ticks(2);
        chk("pre_reset_disp", int'(disp_fill[9:0]), 97);
        drive(50, 15, 1'b0, '0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rgb", int'(rgb), 0);
        chk("async_hud", int'(hud_active), 0);
        for (int i = 0; i < NP; i++) chk("async_disp", int'(disp_fill[10*i +: 10]), W);
        @(negedge clk);
        damage[9:0] = 10'd0;
        reset_n = 1'b1;
        probe("post_reset_fill", 115, 15, FC0);
        probe("post_reset_stock2", 55, 35, FC0);
        scan(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
